// File: rtl/sd_bridge_pkg.sv
// Shared types for the Wishbone-to-byte-port bridge in front of the SD register file.
package sd_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int LANES = 4;

    function automatic logic [7:0] lane_byte(input logic [31:0] dat, input logic [1:0] lane);
        return dat[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sd_wb_byte_bridge.sv
// 32-bit Wishbone classic slave that splits each access into four byte-port cycles,
// lanes 3 down to 0 so the side-effecting byte 0 always lands last.
module sd_wb_byte_bridge
    import sd_bridge_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    input  logic [7:0]        rdata,
    output logic              busy
);

    // state | meaning
    // IDLE  | waiting for cyc&stb; request latched on acceptance
    // XFER  | one byte lane per cycle, lanes 3,2,1,0
    // ACK   | single-cycle wb_ack_o with assembled read data

    state_t              state;
    logic [ADDR_W-3:0]   req_word;
    logic [3:0]          req_sel;
    logic [31:0]         req_dat;
    logic                req_we;
    logic [1:0]          lane;
    logic [1:0]          next_lane;
    logic [31:0]         rbuf;
    logic                unused_adr_lo;

    assign next_lane     = lane - 2'd1;
    assign unused_adr_lo = ^wb_adr_i[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_word <= '0;
            req_sel  <= '0;
            req_dat  <= '0;
            req_we   <= 1'b0;
            lane     <= 2'd0;
            rbuf     <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                    we       <= 1'b0;
                    if (wb_cyc_i && wb_stb_i) begin
                        req_word <= wb_adr_i[ADDR_W-1:2];
                        req_sel  <= wb_sel_i;
                        req_dat  <= wb_dat_i;
                        req_we   <= wb_we_i;
                        lane     <= 2'd3;
                        rbuf     <= '0;
                        // First lane is presented directly so lanes occupy cycles 1..4.
                        addr     <= {wb_adr_i[ADDR_W-1:2], 2'd3};
                        wdata    <= lane_byte(wb_dat_i, 2'd3);
                        we       <= wb_we_i & wb_sel_i[3];
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!wb_cyc_i) begin
                        // Aborted: byte 0 is never reached, so no side effect fires downstream.
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (!req_we) begin
                            rbuf[{lane, 3'b000} +: 8] <= rdata;
                        end
                        if (lane == 2'd0) begin
                            we       <= 1'b0;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= req_we ? 32'd0 : {rbuf[31:8], rdata};
                            state    <= ACK;
                        end else begin
                            lane  <= next_lane;
                            addr  <= {req_word, next_lane};
                            wdata <= lane_byte(req_dat, next_lane);
                            we    <= req_we & req_sel[next_lane];
                        end
                    end
                end
                ACK: begin
                    wb_ack_o <= 1'b0;
                    wb_dat_o <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    we       <= 1'b0;
                    wb_ack_o <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_wb_byte_bridge.sv
// Self-checking bench for sd_wb_byte_bridge: byte-addressed memory behind the port,
// plus an abstract lane/byte model of each Wishbone access.
module tb_sd_wb_byte_bridge;

    localparam int ADDR_W = 7;
    localparam logic [6:0] OFS_ARGUMENT = 7'h00;
    localparam logic [6:0] OFS_CLOCK_D  = 7'h2C;
    localparam logic [6:0] OFS_RESP0    = 7'h10;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_cyc_i, wb_stb_i, wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [3:0]        wb_sel_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic              busy;

    sd_wb_byte_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file stand-in, loadable from the bench while the DUT is held in reset.
    logic [7:0] mem [128];
    logic [7:0] model_mem [128];
    logic       ld_en = 1'b0;
    logic [6:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    assign rdata = mem[addr];
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int         obs_cyc[$];
    logic [6:0] obs_addr[$];
    logic [7:0] obs_data[$];
    int         exp_cyc[$];
    logic [6:0] exp_addr[$];
    logic [7:0] exp_data[$];
    int         ack_cyc;
    logic [31:0] ack_dat;
    logic       busy_c1, busy_after;

    task automatic idle_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    endtask

    task automatic drive_req(input logic w, input logic [6:0] a, input logic [3:0] s, input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w;
        wb_adr_i = a; wb_sel_i = s; wb_dat_i = d;
    endtask

    // Model of a write: selected lanes in order 3..0, lane l on cycle 4-l.
    task automatic model_write(input logic [6:0] a, input logic [3:0] s, input logic [31:0] d, input int base);
        for (int l = 3; l >= 0; l--) begin
            if (s[l]) begin
                exp_cyc.push_back(base + 4 - l);
                exp_addr.push_back({a[6:2], 2'(l)});
                exp_data.push_back(8'((d >> (8 * l)) & 32'hFF));
                model_mem[{a[6:2], 2'(l)}] = 8'((d >> (8 * l)) & 32'hFF);
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        return {model_mem[{a[6:2], 2'd3}], model_mem[{a[6:2], 2'd2}],
                model_mem[{a[6:2], 2'd1}], model_mem[{a[6:2], 2'd0}]};
    endfunction

    // One full access; inputs are scrambled during the transfer to show they are ignored.
    task automatic run_access(input logic w, input logic [6:0] a, input logic [3:0] s, input logic [31:0] d);
        obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
        ack_cyc = -1; ack_dat = '0;
        @(negedge clk);
        drive_req(w, a, s, d);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                busy_c1  = busy;
                wb_we_i  = ~w;
                wb_adr_i = 7'($urandom);
                wb_sel_i = 4'($urandom);
                wb_dat_i = $urandom;
            end
            if (we) begin
                obs_cyc.push_back(c); obs_addr.push_back(addr); obs_data.push_back(wdata);
            end
            if (wb_ack_o) begin
                ack_cyc = c; ack_dat = wb_dat_o;
                idle_bus();
                break;
            end
        end
        idle_bus();
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        #2 rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 7'(i); ld_data = 8'($urandom);
            model_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b1; ld_addr = OFS_RESP0 + 7'd0; ld_data = 8'h78; model_mem[ld_addr] = ld_data;
        @(negedge clk); ld_addr = OFS_RESP0 + 7'd1; ld_data = 8'h56; model_mem[ld_addr] = ld_data;
        @(negedge clk); ld_addr = OFS_RESP0 + 7'd2; ld_data = 8'h34; model_mem[ld_addr] = ld_data;
        @(negedge clk); ld_addr = OFS_RESP0 + 7'd3; ld_data = 8'h12; model_mem[ld_addr] = ld_data;
        @(negedge clk); ld_en = 1'b0;
        n_checks++;
        if ({we, wb_ack_o, busy} !== 3'b000 || addr !== '0 || wdata !== '0 || wb_dat_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b ack=%b busy=%b addr=%h wdata=%h dat_o=%h, required all 0",
                     we, wb_ack_o, busy, addr, wdata, wb_dat_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write(input int n_rand);
        logic [6:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        for (int t = 0; t < 2 + n_rand; t++) begin
            if (t == 0)      begin a = OFS_ARGUMENT; s = 4'hF;    d = 32'hDEADBEEF; end
            else if (t == 1) begin a = OFS_CLOCK_D;  s = 4'b0001; d = 32'h000000A5; end
            else             begin a = 7'($urandom); s = 4'($urandom); d = $urandom; end
            if (t == 2) s = 4'b0000;
            exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
            model_write(a, s, d, 0);
            run_access(1'b1, a, s, d);
            n_checks++;
            if (ack_cyc !== 5) begin
                n_fail++; $display("FAIL write_ack_cycle[%0d]: got %0d, required 5", t, ack_cyc);
            end
            n_checks++;
            if (ack_dat !== 32'd0) begin
                n_fail++; $display("FAIL write_ack_data[%0d]: got %h, required 0", t, ack_dat);
            end
            n_checks++;
            if (busy_c1 !== 1'b1 || busy_after !== 1'b0) begin
                n_fail++; $display("FAIL write_busy[%0d]: got %b/%b, required 1/0", t, busy_c1, busy_after);
            end
            n_checks++;
            if (obs_cyc.size() != exp_cyc.size()) begin
                n_fail++;
                $display("FAIL write_lane_count[%0d]: got %0d we pulses, required %0d", t, obs_cyc.size(), exp_cyc.size());
            end else begin
                for (int i = 0; i < exp_cyc.size(); i++) begin
                    n_checks++;
                    if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                        n_fail++;
                        $display("FAIL write_lane[%0d.%0d]: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                                 t, i, obs_cyc[i], obs_addr[i], obs_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_read(input int n_rand);
        logic [6:0]  a;
        logic [31:0] exp;
        for (int t = 0; t < 1 + n_rand; t++) begin
            a = (t == 0) ? OFS_RESP0 : 7'($urandom);
            exp = model_read(a);
            if (t == 0 && exp !== 32'h12345678) begin
                n_fail++; $display("FAIL read_preload: model holds %h, required 12345678", exp);
            end
            run_access(1'b0, a, 4'($urandom), $urandom);
            n_checks++;
            if (ack_cyc !== 5 || ack_dat !== exp) begin
                n_fail++;
                $display("FAIL read_data[%0d]: got %h at cycle %0d, required %h at cycle 5", t, ack_dat, ack_cyc, exp);
            end
            n_checks++;
            if (obs_cyc.size() != 0) begin
                n_fail++; $display("FAIL read_no_we[%0d]: got %0d we pulses, required 0", t, obs_cyc.size());
            end
        end
    endtask

    task automatic test_abort();
        int n_ack;
        logic b3;
        obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
        exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
        model_write(OFS_ARGUMENT, 4'b1100, 32'hCAFEF00D, 0);
        n_ack = 0;
        b3 = 1'b1;
        @(negedge clk);
        drive_req(1'b1, OFS_ARGUMENT, 4'hF, 32'hCAFEF00D);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (we) begin
                obs_cyc.push_back(c); obs_addr.push_back(addr); obs_data.push_back(wdata);
            end
            if (wb_ack_o) n_ack++;
            if (c == 2) idle_bus();
            if (c == 3) b3 = busy;
        end
        n_checks++;
        if (n_ack != 0) begin
            n_fail++; $display("FAIL abort_no_ack: got %0d acks, required 0", n_ack);
        end
        n_checks++;
        if (b3 !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy: got %b, required 0", b3);
        end
        n_checks++;
        if (obs_cyc.size() != 2) begin
            n_fail++; $display("FAIL abort_lane_count: got %0d, required 2", obs_cyc.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL abort_lane[%0d]: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                             i, obs_cyc[i], obs_addr[i], obs_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        run_access(1'b0, OFS_ARGUMENT, 4'hF, 32'd0);
        n_checks++;
        if (ack_dat !== model_read(OFS_ARGUMENT)) begin
            n_fail++; $display("FAIL abort_readback: got %h, required %h", ack_dat, model_read(OFS_ARGUMENT));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        @(negedge clk);
        drive_req(1'b0, OFS_RESP0, 4'hF, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({we, wb_ack_o, busy} !== 3'b000 || addr !== '0 || wdata !== '0 || wb_dat_o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: we=%b ack=%b busy=%b addr=%h wdata=%h dat_o=%h, required all 0",
                     we, wb_ack_o, busy, addr, wdata, wb_dat_o);
        end
        idle_bus();
        @(negedge clk);
        rst = 1'b1;
        d = $urandom;
        model_write(7'h24, 4'hF, d, 0);
        run_access(1'b1, 7'h24, 4'hF, d);
        n_checks++;
        if (ack_cyc !== 5) begin
            n_fail++; $display("FAIL reset_mid_next_ack: got %0d, required 5", ack_cyc);
        end
        run_access(1'b0, 7'h24, 4'h0, 32'd0);
        n_checks++;
        if (ack_dat !== d) begin
            n_fail++; $display("FAIL reset_mid_readback: got %h, required %h", ack_dat, d);
        end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        logic b6;
        obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
        exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
        model_write(7'h14, 4'hF, 32'h11223344, 0);
        model_write(7'h18, 4'b1010, 32'h55667788, 6);
        b6 = 1'b1;
        @(negedge clk);
        drive_req(1'b1, 7'h14, 4'hF, 32'h11223344);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 6) b6 = busy;
            if (we) begin
                obs_cyc.push_back(c); obs_addr.push_back(addr); obs_data.push_back(wdata);
            end
            if (wb_ack_o) begin
                acks.push_back(c);
                if (acks.size() == 1) drive_req(1'b1, 7'h18, 4'b1010, 32'h55667788);
                else break;
            end
        end
        idle_bus();
        n_checks++;
        if (acks.size() != 2 || acks[0] != 5 || acks[1] != 11) begin
            n_fail++;
            $display("FAIL b2b_acks: got %0d acks first %0d last %0d, required 2 acks at 5 and 11",
                     acks.size(), (acks.size() > 0) ? acks[0] : -1, (acks.size() > 1) ? acks[1] : -1);
        end
        n_checks++;
        if (b6 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap: busy=%b at cycle 6, required 0", b6);
        end
        n_checks++;
        if (obs_cyc.size() != exp_cyc.size()) begin
            n_fail++; $display("FAIL b2b_lane_count: got %0d, required %0d", obs_cyc.size(), exp_cyc.size());
        end else begin
            for (int i = 0; i < exp_cyc.size(); i++) begin
                n_checks++;
                if (obs_cyc[i] !== exp_cyc[i] || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    n_fail++;
                    $display("FAIL b2b_lane[%0d]: got cyc %0d addr %h data %h, required cyc %0d addr %h data %h",
                             i, obs_cyc[i], obs_addr[i], obs_data[i], exp_cyc[i], exp_addr[i], exp_data[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write(12);
        test_read(12);
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_read(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
